hp_tracker: RTL
===============

// Module: hp_tracker
// PURPOSE
// - Per-player hit-point state keeper; sits directly upstream of the HP bar decoder and drives its 3-bit hp input.
// - Applies damage/heal events from collision logic, enforces post-hit invulnerability and death, and handles respawn.
// - Timing is counted in frames via the frame-tick strobe, not in raw clocks.
// PARAMETERS
// - MAX_HP         7    full/respawn HP; legal range 1..7 (3-bit consumer)
// - INVULN_FRAMES  60   frames of damage immunity after a non-lethal hit; >=1
// - REGEN_PERIOD   180  frames between +1 HP regen ticks (only with HP_REGEN_EN); >=1
// PORTS
// - Clk               in   1  system clock; all logic on rising edge
// - Reset             in   1  synchronous, active-high reset
// - frame_clk_rising  in   1  one-Clk pulse per video frame
// - hit               in   1  damage request, one-Clk pulse
// - dmg               in   3  damage amount, sampled when hit=1
// - heal              in   1  heal request, one-Clk pulse
// - heal_amt          in   3  heal amount, sampled when heal=1
// - respawn           in   1  restore player, one-Clk pulse
// - hp                out  3  current HP, 0..MAX_HP, to bar decoder
// - dead              out  1  high while in DEAD
// - invuln            out  1  high while in INVULN
// BEHAVIOUR
// - Reset: hp=MAX_HP, state=ALIVE, dead=0, invuln=0, all frame counters=0.
// - All outputs registered; an event on cycle N is visible on cycle N+1.
// - Priority per cycle: Reset > respawn > hit/heal > frame-tick timers.
// - respawn (any state): hp=MAX_HP, state=ALIVE, counters cleared.
// - Hit accepted only in ALIVE with dmg!=0; ignored in INVULN, DEAD, or dmg=0.
// - Heal accepted in ALIVE and INVULN; ignored in DEAD.
// - Arithmetic in 4-bit unsigned: next = hp - (hit_acc ? dmg : 0) + (heal_acc ? heal_amt : 0),
//   computed signed-safe, clamped to [0, MAX_HP]; never wraps.
// - Same-cycle hit+heal: both applied in one sum; lethality judged on the clamped result.
// - FSM states: ALIVE, INVULN, DEAD.
//   - ALIVE -> DEAD   : accepted hit, next hp == 0.
//   - ALIVE -> INVULN : accepted hit, next hp > 0; load inv_cnt = INVULN_FRAMES.
//   - INVULN: inv_cnt decrements on each frame_clk_rising; on tick with inv_cnt==1 -> ALIVE
//     (exactly INVULN_FRAMES ticks of immunity).
//   - DEAD: hp held at 0; leaves only on respawn or Reset.
// - dead = (state==DEAD); invuln = (state==INVULN); both Moore outputs.
// - Reset mid-INVULN or mid-DEAD returns to reset values next cycle; no residual timer.
// CONFIGURATION
// - Macro HP_REGEN_EN defined: regen_cnt counts frame ticks in ALIVE only; at REGEN_PERIOD
//   ticks, if hp<MAX_HP, hp+1 and regen_cnt=0. regen_cnt cleared on accepted hit, respawn,
//   entry to INVULN/DEAD. Regen tick coinciding with hit/heal is dropped (event wins).
// - Macro undefined: no regen counter or logic synthesized; HP changes only via events/respawn.
// STRUCTURE
// - hp_pkg: typedef enum logic [1:0] {ALIVE, INVULN, DEAD} hp_state_t; localparam HP_W=3;
//   localparam FRAME_CNT_W=8 (width of frame counters).
// - Sub-module frame_timer: loadable frame-tick down-counter with done pulse;
//   used for invulnerability (and regen when HP_REGEN_EN).
// - hp_tracker holds FSM, clamped HP arithmetic, event acceptance.
// TESTING
// - Reset, then idle 10 frames -> hp=7, dead=0, invuln=0 throughout.
// - hit dmg=3 in ALIVE -> next cycle hp=4, invuln=1; second hit dmg=2 within 60 frames -> hp stays 4;
//   after 60th frame tick invuln=0.
// - hp=2, hit dmg=5 -> hp=0, dead=1; heal amt=3 while dead -> hp stays 0; respawn -> hp=7, dead=0.
// - hp=6, heal amt=4 -> hp=7 (clamp); hp=4 same-cycle hit dmg=2 + heal amt=1 -> hp=3, invuln=1.
// - Reset asserted mid-INVULN (frame 30) -> next cycle hp=7, invuln=0; new hit accepted immediately.
// - HP_REGEN_EN: hp=5 in ALIVE, 180 frame ticks -> hp=6; hit at tick 179 -> counter restarts, no regen.

Source files
------------

// File: rtl/hp_pkg.sv
// Shared state encoding, widths and clamp helper for hp_tracker and frame_timer.
// No backpressure anywhere in this slice; all users are single-cycle strobes.
package hp_pkg;

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} hp_state_t;

  localparam int HP_W        = 3;
  localparam int FRAME_CNT_W = 8;

  // (sum - sub) clamped to [0, max]; operands are one bit wider than hp so nothing wraps.
  function automatic logic [HP_W-1:0] clamp_hp(input logic [HP_W:0] sum,
                                               input logic [HP_W:0] sub,
                                               input logic [HP_W:0] max);
    logic [HP_W:0] diff;
    diff = (sum <= sub) ? '0 : (sum - sub);
    if (diff > max) diff = max;
    return diff[HP_W-1:0];
  endfunction

endpackage

// File: rtl/hp_tracker_frame_timer.sv
// Loadable frame-tick down-counter; done is a combinational pulse on the PERIOD-th tick.
// Latency: count updates one Clk after tick/load/clr; no backpressure (tick is a strobe).
module frame_timer #(
  parameter int unsigned W      = 8,
  parameter int unsigned PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic tick,
  output logic done
);

  localparam logic [W-1:0] PERIOD_W = W'(PERIOD);

  logic [W-1:0] cnt_q, cnt_d;

  // A zero count means "idle / freshly cleared": the next tick starts a full period.
  always_comb begin
    done  = tick && ((cnt_q == W'(1)) || ((cnt_q == '0) && (PERIOD_W == W'(1))));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = PERIOD_W;
    end else if (tick) begin
      if (done)              cnt_d = '0;
      else if (cnt_q == '0)  cnt_d = PERIOD_W - W'(1);
      else                   cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hp_tracker.sv
// Per-player HP keeper with post-hit invulnerability, death and respawn; optional regen under HP_REGEN_EN.
// Latency: every event is visible on the registered outputs one Clk later; no backpressure, events are strobes.
import hp_pkg::*;

module hp_tracker #(
  parameter int unsigned MAX_HP        = 7,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned REGEN_PERIOD  = 180
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk_rising,
  input  logic            hit,
  input  logic [HP_W-1:0] dmg,
  input  logic            heal,
  input  logic [HP_W-1:0] heal_amt,
  input  logic            respawn,
  output logic [HP_W-1:0] hp,
  output logic            dead,
  output logic            invuln
);

  localparam logic [HP_W:0]   MAX_W  = (HP_W+1)'(MAX_HP);
  localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);

  hp_state_t       state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            hit_acc, heal_acc;
  logic [HP_W:0]   sum, sub;
  logic [HP_W-1:0] ev_hp;
  logic            inv_load, inv_clr, inv_tick, inv_done;

  assign hit_acc  = hit && (state_q == ALIVE) && (dmg != '0);
  assign heal_acc = heal && (state_q != DEAD);
  assign sum      = {1'b0, hp_q} + (heal_acc ? {1'b0, heal_amt} : '0);
  assign sub      = hit_acc ? {1'b0, dmg} : '0;
  assign ev_hp    = clamp_hp(sum, sub, MAX_W);

  assign inv_tick = frame_clk_rising && (state_q == INVULN);
  assign inv_clr  = respawn;

  frame_timer #(.W(FRAME_CNT_W), .PERIOD(INVULN_FRAMES)) u_inv_timer (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (inv_clr),
    .load (inv_load),
    .tick (inv_tick),
    .done (inv_done)
  );

`ifdef HP_REGEN_EN
  logic regen_clr, regen_tick, regen_done;

  // Regen only advances on quiet ALIVE frames; any event on that cycle swallows the tick.
  assign regen_clr  = respawn || hit_acc;
  assign regen_tick = frame_clk_rising && (state_q == ALIVE) && !respawn && !hit_acc && !heal_acc;

  frame_timer #(.W(FRAME_CNT_W), .PERIOD(REGEN_PERIOD)) u_regen_timer (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (regen_clr),
    .load (1'b0),
    .tick (regen_tick),
    .done (regen_done)
  );
`endif

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    inv_load = 1'b0;
    if (respawn) begin
      state_d = ALIVE;
      hp_d    = MAX_HP_V;
    end else begin
      if (hit_acc || heal_acc) hp_d = ev_hp;
      if (hit_acc) begin
        if (ev_hp == '0) begin
          state_d = DEAD;
        end else begin
          state_d  = INVULN;
          inv_load = 1'b1;
        end
      end else if (inv_done) begin
        state_d = ALIVE;
      end
`ifdef HP_REGEN_EN
      if (regen_done && (hp_q < MAX_HP_V)) hp_d = hp_q + HP_W'(1);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ALIVE;
      hp_q    <= MAX_HP_V;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
    end
  end

  assign hp     = hp_q;
  assign dead   = (state_q == DEAD);
  assign invuln = (state_q == INVULN);

endmodule
